serial_sub_ctrl: RTL and testbench

Bit-serial subtraction controller that computes the unsigned difference of two WIDTH-bit operands with a single 1-bit subtractor cell and a registered borrow. The cell is a full subtractor built from two half subtractors plus an OR for the borrow. The controller captures the operands, clocks them LSB-first through the cell for WIDTH cycles, assembles the result, and reports it with a start/done handshake. It sits between a requesting datapath and the shared subtractor cell, trading latency for area.

---
 rtl/serial_sub_ctrl.sv | 124 ++++++++++++
 tb/tb_serial_sub_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtraction controller: one full-subtractor cell,
// operands shifted LSB-first, result registered on completion.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_zero;

  logic             w_a0;
  logic             w_b0;
  logic             w_d1;
  logic             w_b1;
  logic             w_d;
  logic             w_b2;
  logic             w_br_nxt;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_res_nxt;

  // Full subtractor: two half subtractors, borrows ORed
  assign w_a0      = r_a_sh[0];
  assign w_b0      = r_b_sh[0];
  assign w_d1      = w_a0 ^ w_b0;
  assign w_b1      = ~w_a0 & w_b0;
  assign w_d       = w_d1 ^ r_br;
  assign w_b2      = ~w_d1 & r_br;
  assign w_br_nxt  = w_b1 | w_b2;
  assign w_res_nxt = {w_d, r_res_sh[WIDTH-1:1]};

  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_accept = (r_state == S_IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_state_nxt = S_RUN;
      S_RUN:  if (w_last) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_cnt    <= '0;
      r_br     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_a_sh   <= a;
        r_b_sh   <= b;
        r_res_sh <= '0;
        r_cnt    <= '0;
        r_br     <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_a_sh   <= r_a_sh >> 1;
        r_b_sh   <= r_b_sh >> 1;
        r_res_sh <= w_res_nxt;
        r_br     <= w_br_nxt;
        r_cnt    <= r_cnt + 1'b1;
        if (w_last) begin
          r_diff   <= w_res_nxt;
          r_borrow <= w_br_nxt;
          r_zero   <= ~|w_res_nxt;
        end
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign diff       = r_diff;
  assign borrow_out = r_borrow;
  assign zero       = r_zero;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Testbench for serial_sub_ctrl: directed cases, reset, back-to-back
// and a random sweep against an arithmetic reference model.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         zero;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] got_diff;
  logic         got_bo;
  logic         got_zero;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .diff(diff),
    .borrow_out(borrow_out),
    .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] m_diff(input logic [W-1:0] x, y);
    int unsigned r;
    r = (int'(x) - int'(y) + 256) % 256;
    return W'(r);
  endfunction

  function automatic logic m_bo(input logic [W-1:0] x, y);
    return int'(x) < int'(y);
  endfunction

  // Runs one op from IDLE; optionally disturbs start/a/b at step inj.
  task automatic do_op(input logic [W-1:0] av, bv, input int inj,
                       output int lat, output int ndone,
                       output int nbusy);
    lat = -1;
    ndone = 0;
    nbusy = 0;
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (busy) nbusy++;
    for (int k = 1; k <= 12; k++) begin
      if (k == inj) begin
        start = 1'b1;
        a = 8'h00;
        b = 8'hFF;
      end
      if (k == inj + 1) start = 1'b0;
      @(posedge clk);
      #1;
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = k;
          got_diff = diff;
          got_bo = borrow_out;
          got_zero = zero;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, diff, borrow_out, zero} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %b/%b/%h/%b/%b want all 0",
               busy, done, diff, borrow_out, zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: busy=%b done=%b want 0/0",
               busy, done);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] va[5] = '{8'h35, 8'h12, 8'h5A, 8'h00, 8'hFF};
    logic [W-1:0] vb[5] = '{8'h12, 8'h35, 8'h5A, 8'h01, 8'h00};
    logic [W-1:0] ed[5] = '{8'h23, 8'hDD, 8'h00, 8'hFF, 8'hFF};
    logic         eb[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic         ez[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int lat, nd, nb;
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], 0, lat, nd, nb);
      checks++;
      if (lat != W || nd != 1) begin
        errors++;
        $display("FAIL dir%0d_timing: done at %0d x%0d want %0d x1",
                 i, lat, nd, W);
      end
      checks++;
      if (nb != W + 1) begin
        errors++;
        $display("FAIL dir%0d_busy: %0d cycles want %0d", i, nb, W + 1);
      end
      checks++;
      if (got_diff !== ed[i] || got_bo !== eb[i] || got_zero !== ez[i]) begin
        errors++;
        $display("FAIL dir%0d_result: got %h/%b/%b want %h/%b/%b", i,
                 got_diff, got_bo, got_zero, ed[i], eb[i], ez[i]);
      end
    end
  endtask

  task automatic test_ignore_start;
    int lat, nd, nb;
    do_op(8'h80, 8'h01, 4, lat, nd, nb);
    checks++;
    if (nd != 1 || lat != W) begin
      errors++;
      $display("FAIL ignore_done_count: done at %0d x%0d want %0d x1",
               lat, nd, W);
    end
    checks++;
    if (got_diff !== 8'h7F || got_bo !== 1'b0 || got_zero !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result: got %h/%b/%b want 7f/0/0",
               got_diff, got_bo, got_zero);
    end
    checks++;
    if (diff !== 8'h7F || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_hold: diff=%h busy=%b want 7f/0", diff, busy);
    end
  endtask

  task automatic test_reset_midrun;
    int lat, nd, nb;
    do_op(8'h12, 8'h35, 0, lat, nd, nb);
    checks++;
    if (diff !== 8'hDD) begin
      errors++;
      $display("FAIL rst_prior: diff=%h want dd", diff);
    end
    a = 8'h35;
    b = 8'h12;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({busy, done, diff, borrow_out, zero} !== '0) begin
      errors++;
      $display("FAIL rst_async: got %b/%b/%h/%b/%b want all 0",
               busy, done, diff, borrow_out, zero);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(8'h10, 8'h20, 0, lat, nd, nb);
    checks++;
    if (lat != W || nd != 1 || got_diff !== 8'hF0 || got_bo !== 1'b1) begin
      errors++;
      $display("FAIL rst_after: lat=%0d n=%0d got %h/%b want %0d 1 f0/1",
               lat, nd, got_diff, got_bo, W);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] qa[3];
    logic [W-1:0] qb[3];
    int acc[$];
    int ndn = 0;
    logic pb = 1'b0;
    logic pd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      qa[i] = W'($urandom);
      qb[i] = W'($urandom);
    end
    a = qa[0];
    b = qb[0];
    start = 1'b1;
    for (int e = 0; e < 45; e++) begin
      @(posedge clk);
      #1;
      if (busy && !pb) begin
        acc.push_back(e);
        if (acc.size() < 3) begin
          a = qa[acc.size()];
          b = qb[acc.size()];
        end else begin
          start = 1'b0;
        end
      end
      if (done && pd) begin
        checks++;
        errors++;
        $display("FAIL b2b_pulse: done high two cycles at edge %0d", e);
      end else if (done && ndn < 3) begin
        checks++;
        if (diff !== m_diff(qa[ndn], qb[ndn]) ||
            borrow_out !== m_bo(qa[ndn], qb[ndn]) ||
            zero !== (qa[ndn] == qb[ndn])) begin
          errors++;
          $display("FAIL b2b_res%0d: got %h/%b/%b want %h/%b", ndn,
                   diff, borrow_out, zero, m_diff(qa[ndn], qb[ndn]),
                   m_bo(qa[ndn], qb[ndn]));
        end
        ndn++;
      end
      pb = busy;
      pd = done;
    end
    checks++;
    if (acc.size() != 3 || ndn != 3) begin
      errors++;
      $display("FAIL b2b_count: accepts=%0d dones=%0d want 3/3",
               acc.size(), ndn);
    end else begin
      checks++;
      if (acc[1] - acc[0] != W + 2 || acc[2] - acc[1] != W + 2) begin
        errors++;
        $display("FAIL b2b_spacing: %0d,%0d want %0d", acc[1] - acc[0],
                 acc[2] - acc[1], W + 2);
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] x, y;
    int lat, nd, nb;
    for (int i = 0; i < 1000; i++) begin
      x = W'($urandom);
      y = (i % 10 == 0) ? x : W'($urandom);
      do_op(x, y, 0, lat, nd, nb);
      checks++;
      if (lat != W || nd != 1 || got_diff !== m_diff(x, y) ||
          got_bo !== m_bo(x, y) || got_zero !== (x == y)) begin
        errors++;
        $display("FAIL rnd%0d %h-%h: lat=%0d n=%0d got %h/%b/%b want %h/%b",
                 i, x, y, lat, nd, got_diff, got_bo, got_zero,
                 m_diff(x, y), m_bo(x, y));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
